// File: rtl/dist_pkg.sv
// Shared definitions for the 1:2 stream distributor.
//   CH_0 / CH_1 : values of in_channel selecting output 0 or output 1.
// The beat struct depends on DWIDTH, so it is declared inside the top module.
package dist_pkg;

  localparam logic CH_0 = 1'b0;
  localparam logic CH_1 = 1'b1;

endpackage : dist_pkg

// File: rtl/dist_sync_fifo.sv
// Show-ahead synchronous FIFO built on a register array.
// Ports:
//   clk, reset_n  : rising-edge clock, asynchronous active-low reset
//   wr_en/wr_data : push request; accepted while not full, or when full with a
//                   pop in the same cycle (the freed slot is reused at once)
//   rd_en         : pop request; ignored while empty
//   rd_data       : current head (valid while empty_n)
//   empty_n       : FIFO holds at least one entry
//   count         : occupancy 0..DEPTH (registered)
//   almost_full   : registered count >= FULL_LEVEL, aligned with count
module dist_sync_fifo #(
  parameter int DWIDTH     = 8,
  parameter int DEPTH      = 16,
  parameter int FULL_LEVEL = 12,
  localparam int AWIDTH    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] rd_data,
  output logic              empty_n,
  output logic [AWIDTH:0]   count,
  output logic              almost_full
);

  localparam logic [AWIDTH:0]   FULL_CNT = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0]   AF_CNT   = (AWIDTH+1)'(FULL_LEVEL);
  localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH:0]   count_r;
  logic [AWIDTH:0]   count_next;
  logic              af_r;
  logic              wr_ok;
  logic              rd_ok;

  assign rd_ok = rd_en & (count_r != '0);
  // When full, a same-cycle pop frees the head slot, which is exactly where
  // wr_ptr points, so the write may proceed.
  assign wr_ok = wr_en & ((count_r < FULL_CNT) | rd_ok);

  always_comb begin
    count_next = count_r;
    if (wr_ok && !rd_ok) begin
      count_next = count_r + CNT_ONE;
    end else if (!wr_ok && rd_ok) begin
      count_next = count_r - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      af_r    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      count_r <= count_next;
      af_r    <= (count_next >= AF_CNT);
    end
  end

  // Storage needs no reset: entries are only visible through rd_ptr/count.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  assign rd_data     = mem[rd_ptr];
  assign empty_n     = (count_r != '0);
  assign count       = count_r;
  assign almost_full = af_r;

endmodule : dist_sync_fifo

// File: rtl/dist_2_wrapper_outfill.sv
// 1:2 stream distributor. A one-entry hold stage registers each input beat,
// then writes it into the FIFO selected by its channel tag. Each FIFO drains
// on its own valid/ready handshake.
// Handshake rule (all ports): a beat transfers on a rising edge where valid
// and ready are both high; ready never depends on the same-side valid.
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   in_data/in_channel        : input beat and destination (0 -> out_*_0)
//   in_valid/in_ready         : input handshake
//   out_data_x/out_valid_x    : FIFO x head (show-ahead) and non-empty flag
//   out_ready_x               : consumer x pops the head
//   out_almost_full_x         : FIFO x occupancy >= FULL_LEVEL
//   fill_level_x              : FIFO x occupancy 0..DEPTH
//   beat_cnt_x                : beats written into FIFO x since reset (wraps)
module dist_2_wrapper_outfill
  import dist_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int DEPTH      = 16,
  parameter int FULL_LEVEL = 12,
  localparam int AWIDTH    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_channel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DWIDTH-1:0] out_data_0,
  output logic              out_valid_0,
  input  logic              out_ready_0,
  output logic              out_almost_full_0,
  output logic [AWIDTH:0]   fill_level_0,
  output logic [31:0]       beat_cnt_0,
  output logic [DWIDTH-1:0] out_data_1,
  output logic              out_valid_1,
  input  logic              out_ready_1,
  output logic              out_almost_full_1,
  output logic [AWIDTH:0]   fill_level_1,
  output logic [31:0]       beat_cnt_1
);

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic              ch;
  } dist_beat_t;

  localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH+1)'(DEPTH);

  dist_beat_t      hold_beat;
  logic            hold_valid;
  logic            accept;
  logic            drain;
  logic            pop_0;
  logic            pop_1;
  logic            push_0;
  logic            push_1;
  logic [AWIDTH:0] tgt_count;
  logic            tgt_pop;
  logic [31:0]     beat_cnt_0_r;
  logic [31:0]     beat_cnt_1_r;

  assign pop_0 = out_valid_0 & out_ready_0;
  assign pop_1 = out_valid_1 & out_ready_1;

  always_comb begin
    tgt_count = fill_level_0;
    tgt_pop   = pop_0;
    if (hold_beat.ch == CH_1) begin
      tgt_count = fill_level_1;
      tgt_pop   = pop_1;
    end
  end

  // The hold beat leaves when its target FIFO has room, counting a slot freed
  // by a same-cycle pop. A hold waiting on a full FIFO blocks the input even
  // if the other FIFO is empty: per-channel order needs a single in-order slot.
  assign drain    = hold_valid & ((tgt_count < FULL_CNT) | tgt_pop);
  assign in_ready = ~hold_valid | drain;
  assign accept   = in_valid & in_ready;

  assign push_0 = drain & (hold_beat.ch == CH_0);
  assign push_1 = drain & (hold_beat.ch == CH_1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid <= 1'b0;
      hold_beat  <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_beat  <= '{data: in_data, ch: in_channel};
    end else if (drain) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt_0_r <= '0;
      beat_cnt_1_r <= '0;
    end else begin
      if (push_0) beat_cnt_0_r <= beat_cnt_0_r + 32'd1;
      if (push_1) beat_cnt_1_r <= beat_cnt_1_r + 32'd1;
    end
  end

  assign beat_cnt_0 = beat_cnt_0_r;
  assign beat_cnt_1 = beat_cnt_1_r;

  dist_sync_fifo #(
    .DWIDTH     (DWIDTH),
    .DEPTH      (DEPTH),
    .FULL_LEVEL (FULL_LEVEL)
  ) u_fifo_0 (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (push_0),
    .wr_data     (hold_beat.data),
    .rd_en       (pop_0),
    .rd_data     (out_data_0),
    .empty_n     (out_valid_0),
    .count       (fill_level_0),
    .almost_full (out_almost_full_0)
  );

  dist_sync_fifo #(
    .DWIDTH     (DWIDTH),
    .DEPTH      (DEPTH),
    .FULL_LEVEL (FULL_LEVEL)
  ) u_fifo_1 (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (push_1),
    .wr_data     (hold_beat.data),
    .rd_en       (pop_1),
    .rd_data     (out_data_1),
    .empty_n     (out_valid_1),
    .count       (fill_level_1),
    .almost_full (out_almost_full_1)
  );

endmodule : dist_2_wrapper_outfill
